// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared state type and timing helpers for the image stream generator
package img_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_HBLANK,
    ST_VFRONT
  } state_e;

  function automatic int line_len(input int h_active, input int hb_len);
    return h_active + hb_len;
  endfunction

  function automatic int frame_len(input int h_active, input int hb_len, input int v_active,
                                   input int vs_len, input int vb_len, input int vf_len);
    return (vs_len + vb_len + v_active + vf_len) * line_len(h_active, hb_len);
  endfunction

  // Longest span the shared blanking counter has to cover, in cycles.
  function automatic int blank_max(input int h_active, input int hb_len,
                                   input int vs_len, input int vb_len, input int vf_len);
    int m;
    m = vs_len;
    if (vb_len > m) m = vb_len;
    if (vf_len > m) m = vf_len;
    m = m * line_len(h_active, hb_len);
    if (hb_len > m) m = hb_len;
    return m;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/img_stream_gen.sv
// rtl/img_stream_gen.sv - valid/ready pixel source to vsync/href/clken frame stream
module img_stream_gen
  import img_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int HB_LEN     = 160,
  parameter int VS_LEN     = 2,
  parameter int VB_LEN     = 10,
  parameter int VF_LEN     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  per_frame_vsync,
  output logic                  per_frame_href,
  output logic                  per_frame_clken,
  output logic [DATA_WIDTH-1:0] per_img_y,
  output logic                  frame_done
);

  localparam int LINE_LEN = line_len(H_ACTIVE, HB_LEN);
  localparam int BLK_MAX  = blank_max(H_ACTIVE, HB_LEN, VS_LEN, VB_LEN, VF_LEN);
  localparam int BW       = cnt_width(BLK_MAX);
  localparam int PW       = cnt_width(H_ACTIVE);
  localparam int LW       = cnt_width(V_ACTIVE);

  localparam logic [BW-1:0] VS_LAST   = BW'(VS_LEN * LINE_LEN - 1);
  localparam logic [BW-1:0] VB_LAST   = BW'(VB_LEN * LINE_LEN - 1);
  localparam logic [BW-1:0] VF_LAST   = BW'(VF_LEN * LINE_LEN - 1);
  localparam logic [BW-1:0] HB_LAST   = BW'(HB_LEN - 1);
  localparam logic [PW-1:0] PIX_LAST  = PW'(H_ACTIVE - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(V_ACTIVE - 1);

  state_e                  state_q, state_d;
  logic [BW-1:0]           blk_q, blk_d;
  logic [PW-1:0]           pix_q, pix_d;
  logic [LW-1:0]           line_q, line_d;
  logic                    vsync_q, href_q, clken_q, done_q;
  logic [DATA_WIDTH-1:0]   y_q;
  logic                    hs;
  logic                    frame_end;

  assign s_ready   = (state_q == ST_ACTIVE);
  assign hs        = s_valid & s_ready;
  assign frame_end = (state_q == ST_VFRONT) && (blk_q == VF_LAST);

  // Blanking is timed by blk_q alone, so upstream stalls only stretch ACTIVE.
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    pix_d   = pix_q;
    line_d  = line_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_VSYNC;
          blk_d   = '0;
        end
      end
      ST_VSYNC: begin
        if (blk_q == VS_LAST) begin
          state_d = ST_VBACK;
          blk_d   = '0;
        end else begin
          blk_d = blk_q + BW'(1);
        end
      end
      ST_VBACK: begin
        if (blk_q == VB_LAST) begin
          state_d = ST_ACTIVE;
          blk_d   = '0;
          pix_d   = '0;
          line_d  = '0;
        end else begin
          blk_d = blk_q + BW'(1);
        end
      end
      ST_ACTIVE: begin
        if (hs) begin
          if (pix_q == PIX_LAST) begin
            state_d = ST_HBLANK;
            pix_d   = '0;
            blk_d   = '0;
          end else begin
            pix_d = pix_q + PW'(1);
          end
        end
      end
      ST_HBLANK: begin
        if (blk_q == HB_LAST) begin
          blk_d = '0;
          if (line_q == LINE_LAST) begin
            state_d = ST_VFRONT;
          end else begin
            state_d = ST_ACTIVE;
            line_d  = line_q + LW'(1);
          end
        end else begin
          blk_d = blk_q + BW'(1);
        end
      end
      ST_VFRONT: begin
        if (frame_end) begin
          blk_d   = '0;
          line_d  = '0;
          state_d = enable ? ST_VSYNC : ST_IDLE;
        end else begin
          blk_d = blk_q + BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      pix_q   <= '0;
      line_q  <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      clken_q <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      vsync_q <= (state_q == ST_VSYNC);
      href_q  <= (state_q == ST_ACTIVE);
      clken_q <= hs;
      done_q  <= frame_end;
      if (hs) y_q <= s_data;
    end
  end

  assign per_frame_vsync = vsync_q;
  assign per_frame_href  = href_q;
  assign per_frame_clken = clken_q;
  assign per_img_y       = y_q;
  assign frame_done      = done_q;

endmodule

// File: tb/tb_img_stream_gen.sv
// tb/tb_img_stream_gen.sv - directed self-checking bench for img_stream_gen
module tb_img_stream_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic       s_ready;
  logic       per_frame_vsync, per_frame_href, per_frame_clken, frame_done;
  logic [7:0] per_img_y;

  img_stream_gen #(
    .DATA_WIDTH(8), .H_ACTIVE(4), .V_ACTIVE(3), .HB_LEN(2),
    .VS_LEN(1), .VB_LEN(1), .VF_LEN(1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_y(per_img_y),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int cyc, vs_cnt, sr_cnt, fd_cnt, stray, cur_vs, cur_href, cur_clk;
  int vs_rise[$], vs_len[$], href_rise[$], href_lens[$], href_clk[$], fd_cyc[$];
  logic [7:0] pix[$];
  logic prev_vs = 1'b0, prev_href = 1'b0;
  int stall_rem = 0;
  logic [7:0] stall_val = 8'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    cyc = 0; vs_cnt = 0; sr_cnt = 0; fd_cnt = 0; stray = 0;
    cur_vs = 0; cur_href = 0; cur_clk = 0;
    vs_rise.delete(); vs_len.delete(); href_rise.delete();
    href_lens.delete(); href_clk.delete(); fd_cyc.delete(); pix.delete();
  endtask

  // One clock: the source advances its data only on an accepted handshake.
  task automatic step();
    logic hs;
    if (stall_rem > 0 && s_data == stall_val) begin
      s_valid = 1'b0;
      stall_rem--;
    end else begin
      s_valid = 1'b1;
    end
    #1;
    hs = s_valid & s_ready;
    @(posedge clk);
    #1;
    if (hs === 1'b1) s_data = s_data + 8'd1;
    cyc++;
    if (per_frame_vsync && !prev_vs) begin vs_rise.push_back(cyc); cur_vs = 0; end
    if (per_frame_vsync) begin vs_cnt++; cur_vs++; end
    if (!per_frame_vsync && prev_vs) vs_len.push_back(cur_vs);
    if (per_frame_href && !prev_href) begin href_rise.push_back(cyc); cur_href = 0; cur_clk = 0; end
    if (per_frame_href) cur_href++;
    if (per_frame_clken) begin
      pix.push_back(per_img_y);
      if (per_frame_href) cur_clk++; else stray++;
    end
    if (!per_frame_href && prev_href) begin href_lens.push_back(cur_href); href_clk.push_back(cur_clk); end
    if (s_ready) sr_cnt++;
    if (frame_done) begin fd_cnt++; fd_cyc.push_back(cyc); end
    prev_vs = per_frame_vsync;
    prev_href = per_frame_href;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_data(input string tag, input logic [7:0] val, input int limit);
    int n = 0;
    while (s_data != val && n < limit) begin
      step();
      n++;
    end
    check(tag, s_data, val);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; enable = 1'b0;
    run(n);
    rst = 1'b0;
    s_data = 8'd0;
  endtask

  task automatic check_pixels(input string tag, input int n);
    check({tag, "_npix"}, pix.size(), n);
    for (int i = 0; i < n && i < pix.size(); i++) check({tag, "_pix"}, pix[i], i);
  endtask

  initial begin
    // Reset and idle with enable low
    do_reset(3);
    check("rst_vsync", per_frame_vsync, 0);
    check("rst_href", per_frame_href, 0);
    check("rst_clken", per_frame_clken, 0);
    check("rst_y", per_img_y, 0);
    check("rst_done", frame_done, 0);
    check("rst_ready", s_ready, 0);
    clear_mon();
    run(50);
    check("idle_vs", vs_cnt, 0);
    check("idle_href", href_rise.size(), 0);
    check("idle_pix", pix.size(), 0);
    check("idle_ready", sr_cnt, 0);
    check("idle_done", fd_cnt, 0);
    check("idle_noconsume", s_data, 0);

    // Continuous frames, no stalls
    do_reset(1);
    clear_mon();
    enable = 1'b1;
    run(75);
    check("run_vs_len", vs_len[0], 6);
    check("run_vs_to_href", href_rise[0] - vs_rise[0], 12);
    check("run_href0", href_lens[0], 4);
    check("run_href1", href_lens[1], 4);
    check("run_href2", href_lens[2], 4);
    check("run_clk1", href_clk[1], 4);
    check("run_hgap", href_rise[1] - href_rise[0], 6);
    check("run_hgap2", href_rise[2] - href_rise[1], 6);
    check("run_done_pos", fd_cyc[0] - vs_rise[0], 35);
    check("run_period", vs_rise[1] - vs_rise[0], 36);
    check("run_b2b", vs_rise[1] - fd_cyc[0], 1);
    check("run_ndone", fd_cnt, 2);
    check("run_stray", stray, 0);
    check_pixels("run", 24);

    // Three-cycle stall after the second pixel of line 1
    do_reset(1);
    clear_mon();
    stall_val = 8'd6;
    stall_rem = 3;
    enable = 1'b1;
    run(45);
    check("stall_href0", href_lens[0], 4);
    check("stall_href1", href_lens[1], 7);
    check("stall_clk1", href_clk[1], 4);
    check("stall_href2", href_lens[2], 4);
    check("stall_hgap", href_rise[2] - href_rise[1], 9);
    check("stall_done_pos", fd_cyc[0] - vs_rise[0], 38);
    check("stall_stray", stray, 0);
    check_pixels("stall", 12);

    // Drop enable during line 2
    do_reset(1);
    clear_mon();
    enable = 1'b1;
    run_until_data("drop_reach", 8'd9, 100);
    enable = 1'b0;
    run(60);
    check("drop_ndone", fd_cnt, 1);
    check("drop_vs", vs_cnt, 6);
    check("drop_ready", sr_cnt, 12);
    check_pixels("drop", 12);

    // Reset mid-line 1, then a fresh frame
    do_reset(1);
    clear_mon();
    enable = 1'b1;
    run_until_data("mid_reach", 8'd6, 100);
    rst = 1'b1;
    enable = 1'b0;
    step();
    check("mid_vsync", per_frame_vsync, 0);
    check("mid_href", per_frame_href, 0);
    check("mid_clken", per_frame_clken, 0);
    check("mid_y", per_img_y, 0);
    check("mid_ready", s_ready, 0);
    rst = 1'b0;
    s_data = 8'd0;
    run(5);
    check("mid_nodone", fd_cnt, 0);
    clear_mon();
    enable = 1'b1;
    run(37);
    check("fresh_vs_len", vs_len[0], 6);
    check("fresh_ndone", fd_cnt, 1);
    check("fresh_done_pos", fd_cyc[0] - vs_rise[0], 35);
    check_pixels("fresh", 12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
